// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//   Shared definitions for the instruction-cache refill sequencer:
//   - state_t      : refill FSM states (PF_* are only reached when the
//                    ICACHE_PREFETCH_EN macro is defined)
//   - LINE_BYTES   : bytes per cache line
//   - OFFSET_BITS  : byte-offset bits inside a line
//   - line_align() : clears the line-offset bits of a byte address
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int LINE_BYTES  = 16;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    FILL    = 3'd2,
    RECHECK = 3'd3,
    PF_REQ  = 3'd4,
    PF_FILL = 3'd5
  } state_t;

  // Operates on a wide container so callers of any address width up to 64
  // bits can cast in and out.
  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return {addr[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
// Ports
//   clk    in   rising-edge clock
//   resetn in   asynchronous active-low reset (count -> 0)
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current count, CNT_W bits
// -----------------------------------------------------------------------------
module sat_counter
  import icache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//   Miss/refill sequencer for the instruction cache. Detects a fetch miss,
//   stalls the fetch stage, reads the whole line from instruction memory over
//   a req/ack handshake, writes it into the cache array, then gives the cache
//   tags one cycle to settle before the fetch is re-evaluated.
//
// Optional feature (macro ICACHE_PREFETCH_EN):
//   After each demand fill, one next-line prefetch is issued (PF_REQ/PF_FILL).
//   Fetch is only stalled during the prefetch if it misses itself; such a miss
//   waits for the prefetch fill and then goes through RECHECK. Prefetch fills
//   are not counted. Without the macro FILL always proceeds to RECHECK.
//
// Ports
//   clk         in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   fetch_valid in   fetch stage presents fetch_addr
//   fetch_addr  in   fetch byte address (ADDR_W)
//   cache_hit   in   same-cycle hit flag for fetch_addr
//   stall       out  hold the fetch stage
//   mem_req     out  line read request
//   mem_addr    out  line-aligned request address (ADDR_W)
//   mem_ack     in   mem_rdata valid this cycle
//   mem_rdata   in   returned line (LINE_W)
//   fill_we     out  one-cycle cache-array write strobe
//   fill_addr   out  line-aligned fill address (ADDR_W)
//   fill_data   out  line to write (LINE_W)
//   refill_cnt  out  completed demand refills, saturating (CNT_W)
// -----------------------------------------------------------------------------
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              cache_hit,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_data,
  output logic [CNT_W-1:0]  refill_cnt
);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] line_reg;
  logic              miss;
  logic              demand_fill;

  assign miss = fetch_valid & ~cache_hit;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (miss) state_next = REQ;
      REQ:     if (mem_ack) state_next = FILL;
`ifdef ICACHE_PREFETCH_EN
      FILL:    state_next = PF_REQ;
      PF_REQ:  if (mem_ack) state_next = PF_FILL;
      // A fetch that missed while the prefetch was in flight still needs the
      // tag-settle cycle; otherwise return straight to IDLE.
      PF_FILL: state_next = miss ? RECHECK : IDLE;
`else
      FILL:    state_next = RECHECK;
`endif
      RECHECK: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall   = 1'b0;
    mem_req = 1'b0;
    fill_we = 1'b0;
    case (state_reg)
      IDLE:    stall = miss;
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
      end
      FILL: begin
        stall   = 1'b1;
        fill_we = 1'b1;
      end
      RECHECK: stall = 1'b1;
`ifdef ICACHE_PREFETCH_EN
      // The prefetched line is speculative: only a real miss holds fetch.
      PF_REQ: begin
        stall   = miss;
        mem_req = 1'b1;
      end
      PF_FILL: begin
        stall   = miss;
        fill_we = 1'b1;
      end
`endif
      default: begin
        stall   = 1'b0;
        mem_req = 1'b0;
        fill_we = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address and line latches. The request address is captured once at miss
  // detection, so a redirect of fetch_addr mid-refill cannot disturb it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg <= '0;
    end else if ((state_reg == IDLE) && miss) begin
      addr_reg <= ADDR_W'(line_align(64'(fetch_addr)));
`ifdef ICACHE_PREFETCH_EN
    end else if (state_reg == FILL) begin
      // Next line; the add wraps naturally at the top of the address space.
      addr_reg <= addr_reg + ADDR_W'(LINE_BYTES);
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      line_reg <= '0;
    end else if (mem_ack && ((state_reg == REQ)
`ifdef ICACHE_PREFETCH_EN
                          || (state_reg == PF_REQ)
`endif
                          )) begin
      line_reg <= mem_rdata;
    end
  end

  assign mem_addr  = addr_reg;
  assign fill_addr = addr_reg;
  assign fill_data = line_reg;

  // Only demand fills are counted.
  assign demand_fill = (state_reg == FILL);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_refill_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (demand_fill),
    .count  (refill_cnt)
  );

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
//   Scoreboard bench for icache_refill_ctrl. Expected line requests are queued
//   when a miss is driven; each request seen on mem_req queues the expected
//   fill, and each fill_we strobe pops and compares it. A small FIFO cache
//   model supplies cache_hit from the lines actually filled. The DUT counter
//   is built narrow so saturation is reachable in a short run.
//   Honours ICACHE_PREFETCH_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int TB_CNT_W = 8;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef ICACHE_PREFETCH_EN
  localparam int BASE_LAT = 2;  // miss, FILL; release in PF_REQ on the hit
`else
  localparam int BASE_LAT = 3;  // miss, FILL, RECHECK
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              cache_hit;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;
  logic [LINE_W-1:0] fill_data;
  logic [TB_CNT_W-1:0] refill_cnt;

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .cache_hit   (cache_hit),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .fill_we     (fill_we),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data),
    .refill_cnt  (refill_cnt)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        pf;
  } req_t;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         pf;
  } fill_t;

  req_t  exp_req_q[$];
  fill_t exp_fill_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  int ack_lat = 1;
  int resp_cnt = 0;
  bit resp_en = 1'b1;
  bit force_ack = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] data_for(input logic [31:0] a);
    if (a == 32'h0)
      return {32'hDEADBEEF, 32'hABABABAB, 32'hCDCDCDCD, 32'hEFEFEFEF};
    return {a ^ 32'h5A5A0F0F, ~a, a + 32'h12345678, {a[15:0], a[31:16]}};
  endfunction

  // ---------------------------------------------------------------------------
  // Cache model: 8-entry FIFO of line tags written by fill_we
  // ---------------------------------------------------------------------------
  bit [27:0] tag_mem [8];
  bit        vld_mem [8];
  bit [2:0]  fill_ptr;

  always @(posedge clk) begin
    if (fill_we) begin
      tag_mem[fill_ptr] <= fill_addr[31:4];
      vld_mem[fill_ptr] <= 1'b1;
      fill_ptr          <= fill_ptr + 3'd1;
    end
  end

  always_comb begin
    cache_hit = 1'b0;
    for (int i = 0; i < 8; i++)
      if (vld_mem[i] && (tag_mem[i] == fetch_addr[31:4])) cache_hit = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Memory responder: ack after ack_lat request cycles, data from data_for()
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        mem_ack  = force_ack;
        resp_cnt = 0;
      end else if (mem_req && !mem_ack) begin
        resp_cnt++;
        if (resp_cnt >= ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = data_for(mem_addr);
          resp_cnt  = 0;
        end
      end else begin
        mem_ack  = 1'b0;
        resp_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic        mon_prev_req = 1'b0;
  logic [31:0] mon_addr = '0;
  logic        mon_pf = 1'b0;
  req_t        mon_r;
  fill_t       mon_f;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mon_prev_req = 1'b0;
      end else begin
        if (mem_req && !mon_prev_req) begin
          if (exp_req_q.size() == 0) begin
            check("unexpected_req", mem_req, 1'b0);
          end else begin
            mon_r    = exp_req_q.pop_front();
            mon_addr = mon_r.addr;
            mon_pf   = mon_r.pf;
            exp_fill_q.push_back('{addr: mon_addr, data: data_for(mon_addr), pf: mon_pf});
            $display("req  addr=%08h pf=%0d", mon_addr, mon_pf);
          end
        end
        if (mem_req) check("mem_addr", mem_addr, mon_addr);
        if (fill_we) begin
          if (exp_fill_q.size() == 0) begin
            check("unexpected_fill", fill_we, 1'b0);
          end else begin
            mon_f = exp_fill_q.pop_front();
            check("fill_addr", fill_addr, mon_f.addr);
            check("fill_data", fill_data, mon_f.data);
            $display("fill addr=%08h pf=%0d data=%032h", fill_addr, mon_f.pf, fill_data);
`ifdef ICACHE_PREFETCH_EN
            if (!mon_f.pf) exp_req_q.push_front('{addr: mon_f.addr + 32'd16, pf: 1'b1});
`endif
          end
        end
        mon_prev_req = mem_req;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic wait_release(output int cyc);
    bit done = 1'b0;
    cyc = 0;
    while (!done) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (cyc >= 300) begin
          check("release_timeout", stall, 1'b0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_req();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && (n < 50));
    if (!mem_req) check("req_timeout", mem_req, 1'b1);
  endtask

  task automatic wait_quiet();
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      #1;
      if (!mem_req && !fill_we && (exp_req_q.size() == 0) && (exp_fill_q.size() == 0)) begin
        done = 1'b1;
      end else begin
        n++;
        if (n >= 300) begin
          check("quiet_timeout", {mem_req, fill_we, 30'(exp_req_q.size()), 30'(exp_fill_q.size())}, '0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic bump_cnt();
    if (exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  task automatic do_miss(input logic [31:0] a, input int lat);
    int cyc;
    exp_req_q.push_back('{addr: {a[31:4], 4'h0}, pf: 1'b0});
    ack_lat = lat;
    @(posedge clk); #1;
    fetch_valid = 1'b1;
    fetch_addr  = a;
    wait_release(cyc);
    check("miss_latency", cyc, BASE_LAT + lat);
    bump_cnt();
    @(posedge clk); #1;
    fetch_valid = 1'b0;
    check("refill_cnt", refill_cnt, exp_cnt);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    resetn      = 1'b0;
    fetch_valid = 1'b0;
    fetch_addr  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_fill_we", fill_we, 1'b0);
    check("rst_fill_addr", fill_addr, 32'h0);
    check("rst_fill_data", fill_data, 128'h0);
    check("rst_refill_cnt", refill_cnt, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // 1: reset in the middle of a request, then a late ack
    resp_en = 1'b0;
    exp_req_q.push_back('{addr: 32'h300, pf: 1'b0});
    @(posedge clk); #1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h304;
    wait_req();
    #2;
    resetn      = 1'b0;
    fetch_valid = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_stall", stall, 1'b0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_fill_we", fill_we, 1'b0);
    exp_req_q.delete();
    exp_fill_q.delete();
    @(posedge clk); #1;
    resetn    = 1'b1;
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("late_ack_fill_we", fill_we, 1'b0);
      check("late_ack_mem_req", mem_req, 1'b0);
    end
    force_ack = 1'b0;
    resp_en   = 1'b1;
    @(negedge clk);
    check("late_ack_cnt", refill_cnt, 0);

    // 2: miss at 0x7, ack on the third request cycle
    do_miss(32'h7, 3);
    wait_quiet();

    // 3: hit -> no stall, no request
    @(posedge clk); #1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'hC;
    repeat (4) begin
      @(negedge clk);
      check("hit_stall", stall, 1'b0);
      check("hit_mem_req", mem_req, 1'b0);
    end
    @(posedge clk); #1;
    fetch_valid = 1'b0;

    // 4: redirect during REQ; latched line completes, then the new miss
    exp_req_q.push_back('{addr: 32'h40, pf: 1'b0});
    exp_req_q.push_back('{addr: 32'h100, pf: 1'b0});
    ack_lat = 3;
    @(posedge clk); #1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h40;
    wait_req();
    @(posedge clk); #1;
    fetch_addr = 32'h100;
    wait_release(cyc);
    bump_cnt();
    bump_cnt();
    @(posedge clk); #1;
    fetch_valid = 1'b0;
    check("redirect_cnt", refill_cnt, exp_cnt);
    wait_quiet();

    // 5: saturation of the refill counter
    for (int k = 0; k < 260; k++) begin
      do_miss(32'h1000 + 32'((k % 16) * 32) + 32'd4, 1 + (k % 3));
      wait_quiet();
    end
    check("sat_cnt", refill_cnt, CNT_MAX);

`ifdef ICACHE_PREFETCH_EN
    // 6: wrap-around prefetch, and a miss held behind the prefetch
    do_miss(32'hFFFFFFF4, 4);
    exp_req_q.push_back('{addr: 32'h200, pf: 1'b0});
    ack_lat = 4;
    @(posedge clk); #1;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h208;
    @(negedge clk);
    check("pf_hold_stall", stall, 1'b1);
    check("pf_hold_req", mem_req, 1'b1);
    check("pf_hold_addr", mem_addr, 32'h0);
    wait_release(cyc);
    bump_cnt();
    @(posedge clk); #1;
    fetch_valid = 1'b0;
    wait_quiet();
    check("pf_cnt", refill_cnt, exp_cnt);
`endif

    check("queues_empty", 32'(exp_req_q.size() + exp_fill_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
